// File: rtl/red_lane_serializer.sv
// red_lane_serializer: unpacks an operand pair {b,a} into sign-extended lanes, one per beat.
// Optional RED_SUM_EN adds a running lane sum that reproduces the RED result.
module red_lane_serializer #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 8,
    localparam int NUM_LANES = 2 * DATA_W / LANE_W,
    localparam int IDX_W = $clog2(NUM_LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
`ifdef RED_SUM_EN
    ,
    output logic              sum_valid,
    output logic [DATA_W-1:0] sum_data
`endif
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state;
    logic [2*DATA_W-1:0] sr;
`ifdef RED_SUM_EN
    logic [DATA_W-1:0] acc;
`endif
    function automatic logic [DATA_W-1:0] sext(input logic [LANE_W-1:0] l);
        return {{(DATA_W-LANE_W){l[LANE_W-1]}}, l};
    endfunction
    assign in_ready = (state == IDLE);
    // out_data always presents the low lane of sr; the next lane is read pre-shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
`ifdef RED_SUM_EN
            acc       <= '0;
            sum_valid <= 1'b0;
            sum_data  <= '0;
`endif
        end else begin
`ifdef RED_SUM_EN
            sum_valid <= 1'b0;
`endif
            if (state == IDLE) begin
                if (in_valid) begin
                    state     <= SEND;
                    sr        <= {in_b, in_a};
                    out_valid <= 1'b1;
                    out_data  <= sext(in_a[LANE_W-1:0]);
                    out_idx   <= '0;
                    out_last  <= (NUM_LANES == 1);
`ifdef RED_SUM_EN
                    acc       <= '0;
`endif
                end
            end else if (out_ready) begin
`ifdef RED_SUM_EN
                acc <= acc + out_data;
`endif
                if (out_last) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
`ifdef RED_SUM_EN
                    sum_valid <= 1'b1;
                    sum_data  <= acc + out_data;
`endif
                end else begin
                    sr       <= sr >> LANE_W;
                    out_data <= sext(sr[LANE_W +: LANE_W]);
                    out_idx  <= out_idx + 1'b1;
                    out_last <= (out_idx == IDX_W'(NUM_LANES - 2));
                end
            end
        end
    end
endmodule

// File: tb/tb_red_lane_serializer.sv
// tb_red_lane_serializer: directed and random checks of red_lane_serializer against a lane model.
module tb_red_lane_serializer;
    localparam int NL = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_ready, out_valid, out_last;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
`ifdef RED_SUM_EN
    logic        sum_valid;
    logic [15:0] sum_data;
`endif
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    red_lane_serializer #(.DATA_W(16), .LANE_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
`ifdef RED_SUM_EN
        , .sum_valid(sum_valid), .sum_data(sum_data)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lane k of the 32-bit word {b,a}, taken as a signed byte and widened to 16 bits
    function automatic logic [15:0] lane(input logic [15:0] a, input logic [15:0] b, input int k);
        int v;
        v = (int'(k < 2 ? a : b) >> (8 * (k % 2))) & 255;
        if (v >= 128) v -= 256;
        return 16'(v);
    endfunction

    task automatic accept(input logic [15:0] a, input logic [15:0] b, input bit hold);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", in_ready, 1);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic beats(input logic [15:0] a, input logic [15:0] b, input int stall_k, input int stall_n);
        int s = 0;
        for (int k = 0; k < NL; k++) begin
            chk("valid", out_valid, 1);
            chk("data", out_data, lane(a, b, k));
            chk("idx", out_idx, k);
            chk("last", out_last, k == NL - 1);
            chk("busy", in_ready, 0);
            s += int'($signed(lane(a, b, k)));
            if (k == stall_k) begin
                out_ready = 1'b0;
                repeat (stall_n) begin
                    @(posedge clk); #1;
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, lane(a, b, k));
                    chk("stall_idx", out_idx, k);
                    chk("stall_last", out_last, k == NL - 1);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("idle_valid", out_valid, 0);
        chk("idle_ready", in_ready, 1);
`ifdef RED_SUM_EN
        chk("sum_valid", sum_valid, 1);
        chk("sum_data", sum_data, 16'(s));
`endif
    endtask

    initial begin
        logic [15:0] a, b;
        int last_cyc;
        #7;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ready", in_ready, 1);
`ifdef RED_SUM_EN
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_sum_data", sum_data, 0);
`endif
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        // basic pair, no stall
        accept(16'h7F01, 16'h80FF, 0);
        beats(16'h7F01, 16'h80FF, -1, 0);
        // stall 3 cycles on lane 1
        accept(16'h7F01, 16'h80FF, 0);
        beats(16'h7F01, 16'h80FF, 1, 3);
        // in_valid held through SEND with new operands
        accept(16'h1234, 16'hABCD, 1);
        in_a = 16'h8081;
        in_b = 16'hFE02;
        beats(16'h1234, 16'hABCD, -1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        beats(16'h8081, 16'hFE02, -1, 0);
        // async reset mid-cycle after first beat
        accept(16'h7F01, 16'h80FF, 0);
        @(posedge clk); #3;
        chk("pre_rst_idx", out_idx, 1);
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_idx", out_idx, 0);
        chk("arst_last", out_last, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_ready", in_ready, 1);
        end
        // all-positive lanes
        accept(16'h7F7F, 16'h7F7F, 0);
        beats(16'h7F7F, 16'h7F7F, -1, 0);
`ifdef RED_SUM_EN
        chk("sum_0x1fc", sum_data, 16'h01FC);
        @(posedge clk); #1;
        chk("sum_pulse_end", sum_valid, 0);
        chk("sum_hold", sum_data, 16'h01FC);
`endif
        // random back-to-back pairs at full throughput
        in_valid = 1'b1;
        out_ready = 1'b1;
        last_cyc = 0;
        for (int p = 0; p < 20; p++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            chk("rand_ready", in_ready, 1);
            if (p > 0) chk("rand_period", cyc - last_cyc, 5);
            last_cyc = cyc;
            in_a = a;
            in_b = b;
            @(posedge clk); #1;
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            beats(a, b, -1, 0);
        end
        in_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
